// File: rtl/instruction_cache.sv
// Direct-mapped instruction cache: 8 lines x 16-byte blocks, 128-bit block refill.
// Optional hit/miss counters are enabled by defining ICACHE_STATS_EN.
module instruction_cache (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [31:0]  PC,
  output logic [31:0]  INSTRUCTION,
  output logic         BUSYWAIT,
  output logic         MEM_READ,
  output logic [5:0]   MEM_ADDRESS,
  input  logic [127:0] MEM_READDATA,
  input  logic         MEM_BUSYWAIT
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0]  HIT_COUNT,
  output logic [15:0]  MISS_COUNT
`endif
);

  localparam int NUM_LINES = 8;
  localparam int WORDS     = 4;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_UPDATE} state_e;

  state_e state_q, state_d;

  logic [NUM_LINES-1:0]                valid_q;
  logic [NUM_LINES-1:0][2:0]           tag_q;
  logic [NUM_LINES-1:0][WORDS-1:0][31:0] data_q;
  logic [WORDS-1:0][31:0]              fill_q;

  logic [2:0] tag, index;
  logic [1:0] offset;
  logic       hit;
  logic       unused_pc;

  assign tag       = PC[9:7];
  assign index     = PC[6:4];
  assign offset    = PC[3:2];
  assign unused_pc = ^{PC[31:10], PC[1:0]};

  // Unwritten lines hold X data/tags; the valid bit masks them from hit.
  assign hit         = valid_q[index] && (tag_q[index] == tag);
  assign INSTRUCTION = data_q[index][offset];
  assign MEM_ADDRESS = PC[9:4];

  always_comb begin
    state_d  = state_q;
    BUSYWAIT = 1'b1;
    MEM_READ = 1'b0;
    case (state_q)
      S_IDLE: begin
        BUSYWAIT = !hit;
        if (!hit) state_d = S_READ;
      end
      S_READ: begin
        MEM_READ = 1'b1;
        if (!MEM_BUSYWAIT) state_d = S_UPDATE;
      end
      S_UPDATE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_UPDATE) valid_q[index] <= 1'b1;
    end
  end

  // Block is latched on the edge leaving S_READ, installed one cycle later.
  always_ff @(posedge CLK) begin
    if (state_q == S_READ && !MEM_BUSYWAIT) fill_q <= MEM_READDATA;
    if (state_q == S_UPDATE && !RESET) begin
      data_q[index] <= fill_q;
      tag_q[index]  <= tag;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [15:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == S_IDLE) begin
      if (hit && hit_cnt_q != 16'hFFFF)   hit_cnt_q  <= hit_cnt_q + 16'd1;
      if (!hit && miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
    end
  end

  assign HIT_COUNT  = hit_cnt_q;
  assign MISS_COUNT = miss_cnt_q;
`endif

endmodule

// File: tb/tb_instruction_cache.sv
// Directed bench for instruction_cache with a 5-cycle block memory model.
module tb_instruction_cache;

  logic         CLK = 1'b0;
  logic         RESET;
  logic [31:0]  PC;
  logic [31:0]  INSTRUCTION;
  logic         BUSYWAIT;
  logic         MEM_READ;
  logic [5:0]   MEM_ADDRESS;
  logic [127:0] MEM_READDATA;
  logic         MEM_BUSYWAIT;
`ifdef ICACHE_STATS_EN
  logic [15:0]  HIT_COUNT, MISS_COUNT;
`endif

  int tests = 0;
  int fails = 0;
  int mem_cnt = 0;

  always #5 CLK = ~CLK;

  instruction_cache dut (
    .CLK(CLK), .RESET(RESET), .PC(PC), .INSTRUCTION(INSTRUCTION),
    .BUSYWAIT(BUSYWAIT), .MEM_READ(MEM_READ), .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
`ifdef ICACHE_STATS_EN
    , .HIT_COUNT(HIT_COUNT), .MISS_COUNT(MISS_COUNT)
`endif
  );

  // Memory: busy for the first 4 request cycles, data valid on the 5th.
  // Block b word k = 32'hC0DE_0000 | b<<8 | k.
  always_ff @(posedge CLK) mem_cnt <= MEM_READ ? mem_cnt + 1 : 0;
  assign MEM_BUSYWAIT = MEM_READ && (mem_cnt < 4);
  always_comb begin
    MEM_READDATA = '0;
    for (int k = 0; k < 4; k++)
      MEM_READDATA[32*k +: 32] = 32'hC0DE_0000 | ({26'd0, MEM_ADDRESS} << 8) | k;
  end

  // Called right after PC is driven at a negedge; counts stalled cycles.
  task automatic fill_wait(output int cyc, output bit saw_rd, output logic [5:0] addr);
    cyc = 0; saw_rd = 0; addr = 'x;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (!BUSYWAIT) return;
      cyc++;
      if (MEM_READ) begin saw_rd = 1; addr = MEM_ADDRESS; end
      @(negedge CLK);
    end
  endtask

  task automatic do_reset(input logic [31:0] pc);
    @(negedge CLK);
    RESET = 1; PC = pc;
    @(negedge CLK); @(negedge CLK);
    RESET = 0;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    RESET = 1; PC = 32'h3F0;
    @(negedge CLK); #1;
    tests++;
    if (MEM_READ !== 1'b0 || BUSYWAIT !== 1'b1) begin
      fails++; $display("FAIL reset_outputs: MEM_READ=%b BUSYWAIT=%b, need 0/1", MEM_READ, BUSYWAIT);
    end
    tests++;
    if (MEM_ADDRESS !== 6'h3F) begin
      fails++; $display("FAIL reset_addr: got %h need 3f", MEM_ADDRESS);
    end
    do_reset(32'h0);
  endtask

  task automatic test_cold_miss();
    int c; bit r; logic [5:0] a;
    fill_wait(c, r, a);
    tests++;
    if (c !== 7) begin fails++; $display("FAIL cold_stall: got %0d cycles need 7", c); end
    tests++;
    if (r !== 1'b1 || a !== 6'h00) begin
      fails++; $display("FAIL cold_memread: saw=%b addr=%h need 1/00", r, a);
    end
    tests++;
    if (INSTRUCTION !== 32'hC0DE_0000 || BUSYWAIT !== 1'b0) begin
      fails++; $display("FAIL cold_inst: got %h bw=%b need c0de0000/0", INSTRUCTION, BUSYWAIT);
    end
  endtask

  task automatic test_seq_hits();
    logic [31:0] exp [3] = '{32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003};
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      PC = 32'(4 * (i + 1));
      #1;
      tests++;
      if (INSTRUCTION !== exp[i] || BUSYWAIT !== 1'b0 || MEM_READ !== 1'b0) begin
        fails++;
        $display("FAIL seq_hit%0d: inst=%h bw=%b rd=%b need %h/0/0", i, INSTRUCTION, BUSYWAIT, MEM_READ, exp[i]);
      end
    end
  endtask

  task automatic test_conflict();
    int c; bit r; logic [5:0] a;
    @(negedge CLK); PC = 32'h80;
    fill_wait(c, r, a);
    tests++;
    if (c !== 7 || a !== 6'h08) begin
      fails++; $display("FAIL conflict_fill: cycles=%0d addr=%h need 7/08", c, a);
    end
    tests++;
    if (INSTRUCTION !== 32'hC0DE_0800) begin
      fails++; $display("FAIL conflict_inst: got %h need c0de0800", INSTRUCTION);
    end
    @(negedge CLK); PC = 32'h0;
    fill_wait(c, r, a);
    tests++;
    if (c !== 7 || a !== 6'h00 || INSTRUCTION !== 32'hC0DE_0000) begin
      fails++; $display("FAIL conflict_back: cycles=%0d addr=%h inst=%h need 7/00/c0de0000", c, a, INSTRUCTION);
    end
  endtask

  task automatic test_distinct_index();
    int c; bit r; logic [5:0] a;
    @(negedge CLK); PC = 32'h1C;
    fill_wait(c, r, a);
    tests++;
    if (c !== 7 || a !== 6'h01 || INSTRUCTION !== 32'hC0DE_0103) begin
      fails++; $display("FAIL distinct_fill: cycles=%0d addr=%h inst=%h need 7/01/c0de0103", c, a, INSTRUCTION);
    end
    @(negedge CLK); PC = 32'h0;
    fill_wait(c, r, a);
    tests++;
    if (c !== 0 || INSTRUCTION !== 32'hC0DE_0000) begin
      fails++; $display("FAIL distinct_keep: stall=%0d inst=%h need 0/c0de0000", c, INSTRUCTION);
    end
  endtask

  task automatic test_reset_mid_fill();
    int c; bit r; logic [5:0] a;
    do_reset(32'h0);
    @(negedge CLK); @(negedge CLK); @(negedge CLK);
    #1;
    tests++;
    if (MEM_READ !== 1'b1) begin fails++; $display("FAIL midfill_pre: MEM_READ=%b need 1", MEM_READ); end
    RESET = 1;
    @(negedge CLK); #1;
    tests++;
    if (MEM_READ !== 1'b0 || BUSYWAIT !== 1'b1) begin
      fails++; $display("FAIL midfill_abort: rd=%b bw=%b need 0/1", MEM_READ, BUSYWAIT);
    end
    @(negedge CLK);
    RESET = 0;
    fill_wait(c, r, a);
    tests++;
    if (c !== 7 || r !== 1'b1) begin
      fails++; $display("FAIL midfill_refill: cycles=%0d saw=%b need 7/1", c, r);
    end
  endtask

`ifdef ICACHE_STATS_EN
  task automatic test_stats();
    int c; bit r; logic [5:0] a;
    do_reset(32'h0);
    fill_wait(c, r, a);
    repeat (4) @(negedge CLK);
    #1;
    tests++;
    if (MISS_COUNT !== 16'd1 || HIT_COUNT !== 16'd4) begin
      fails++; $display("FAIL stats: miss=%0d hit=%0d need 1/4", MISS_COUNT, HIT_COUNT);
    end
  endtask
`endif

  initial begin
    RESET = 1; PC = 0;
    test_reset();
    test_cold_miss();
    test_seq_hits();
    test_conflict();
    test_distinct_index();
    test_reset_mid_fill();
`ifdef ICACHE_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
